// File: rtl/nway_tag_ctrl.sv
// +--------------------------------------------------------------------------+
// | Module      : nway_tag_ctrl                                              |
// | Description : Tag lookup and miss controller for a 4-way, 16-set cache.  |
// |               Detects hit/miss, picks a victim way (invalid way first,   |
// |               otherwise the lru_table victim) and runs a memory fill.    |
// | Options     : define NWAY_TAG_STATS_EN to add saturating hit/miss        |
// |               counters (hit_cnt_o / miss_cnt_o).                         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module nway_tag_ctrl #(
    parameter int ADDR_W   = 16,
    parameter int OFFSET_W = 4,
    parameter int LRU_LAT  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    output logic              req_ready_o,
    output logic              resp_valid_o,
    output logic              resp_hit_o,
    output logic [1:0]        resp_way_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ack_i,
    output logic [3:0]        lru_set_o,
    output logic [1:0]        lru_way_o,
    output logic              lru_access_o,
    output logic              lru_update_o,
    input  logic [1:0]        lru_victim_i
`ifdef NWAY_TAG_STATS_EN
    ,
    output logic [15:0]       hit_cnt_o,
    output logic [15:0]       miss_cnt_o
`endif
);

    localparam int TAG_W = ADDR_W - OFFSET_W - 4;
    localparam int CNT_W = $clog2(LRU_LAT + 2);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOOKUP = 2'd1,
        S_VICTIM = 2'd2,
        S_FILL   = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [TAG_W-1:0]     r_tag_mem [0:15][0:3];
    logic [15:0][3:0]     r_valid;
    logic [TAG_W-1:0]     r_tag;
    logic [3:0]           r_set;
    logic [1:0]           r_fill_way;
    logic [CNT_W-1:0]     r_cnt;

    logic                 w_hit;
    logic [1:0]           w_hit_way;
    logic                 w_inv;
    logic [1:0]           w_inv_way;
    logic                 w_accept;
    logic                 w_hit_rsp;
    logic                 w_start_fill;
    logic                 w_fill_done;
    logic [1:0]           w_fill_way_nxt;

    // Offset bits select a byte within the line and play no part in lookup.
    logic                 w_unused_offset;
    assign w_unused_offset = ^req_addr_i[OFFSET_W-1:0];

    assign req_ready_o = (r_state == S_IDLE);

    // Compare latched tag against all ways; loop runs high-to-low so the lowest index wins.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = 2'd0;
        w_inv     = 1'b0;
        w_inv_way = 2'd0;
        for (int w = 3; w >= 0; w--) begin
            if (r_valid[r_set][w] && (r_tag_mem[r_set][w] == r_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = 2'(w);
            end
            if (!r_valid[r_set][w]) begin
                w_inv     = 1'b1;
                w_inv_way = 2'(w);
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and single-cycle action strobes.
    always_comb begin
        w_state_nxt    = r_state;
        w_accept       = 1'b0;
        w_hit_rsp      = 1'b0;
        w_start_fill   = 1'b0;
        w_fill_done    = 1'b0;
        w_fill_way_nxt = r_fill_way;
        case (r_state)
            S_IDLE: begin
                if (req_valid_i) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (w_hit) begin
                    w_hit_rsp   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (w_inv) begin
                    w_start_fill   = 1'b1;
                    w_fill_way_nxt = w_inv_way;
                    w_state_nxt    = S_FILL;
                end else if (LRU_LAT <= 1) begin
                    w_start_fill   = 1'b1;
                    w_fill_way_nxt = lru_victim_i;
                    w_state_nxt    = S_FILL;
                end else begin
                    w_state_nxt = S_VICTIM;
                end
            end
            S_VICTIM: begin
                // r_cnt counts cycles since LOOKUP entry; victim is valid on the final count.
                if (r_cnt >= CNT_W'(LRU_LAT)) begin
                    w_start_fill   = 1'b1;
                    w_fill_way_nxt = lru_victim_i;
                    w_state_nxt    = S_FILL;
                end
            end
            S_FILL: begin
                if (mem_ack_i) begin
                    w_fill_done = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Request latch, victim counter, valid array and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tag        <= '0;
            r_set        <= '0;
            r_fill_way   <= '0;
            r_cnt        <= '0;
            r_valid      <= '0;
            resp_valid_o <= 1'b0;
            resp_hit_o   <= 1'b0;
            resp_way_o   <= '0;
            mem_req_o    <= 1'b0;
            mem_addr_o   <= '0;
            lru_set_o    <= '0;
            lru_way_o    <= '0;
            lru_access_o <= 1'b0;
            lru_update_o <= 1'b0;
        end else begin
            resp_valid_o <= 1'b0;
            lru_access_o <= 1'b0;
            lru_update_o <= 1'b0;
            if (w_accept) begin
                r_tag     <= req_addr_i[ADDR_W-1:OFFSET_W+4];
                r_set     <= req_addr_i[OFFSET_W+3:OFFSET_W];
                lru_set_o <= req_addr_i[OFFSET_W+3:OFFSET_W];
                r_cnt     <= CNT_W'(1);
            end else if ((r_state == S_LOOKUP) || (r_state == S_VICTIM)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_hit_rsp) begin
                resp_valid_o <= 1'b1;
                resp_hit_o   <= 1'b1;
                resp_way_o   <= w_hit_way;
                lru_way_o    <= w_hit_way;
                lru_access_o <= 1'b1;
            end
            if (w_start_fill) begin
                r_fill_way <= w_fill_way_nxt;
                mem_req_o  <= 1'b1;
                mem_addr_o <= {r_tag, r_set, {OFFSET_W{1'b0}}};
            end
            if (w_fill_done) begin
                r_valid[r_set][r_fill_way] <= 1'b1;
                mem_req_o    <= 1'b0;
                resp_valid_o <= 1'b1;
                resp_hit_o   <= 1'b0;
                resp_way_o   <= r_fill_way;
                lru_way_o    <= r_fill_way;
                lru_update_o <= 1'b1;
            end
        end
    end

    // Tag storage has no reset; entries are only trusted through the valid array.
    always_ff @(posedge clk) begin
        if (w_fill_done) begin
            r_tag_mem[r_set][r_fill_way] <= r_tag;
        end
    end

`ifdef NWAY_TAG_STATS_EN
    // Saturating hit/miss counters, stepped in the same edge as the response pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else begin
            if (w_hit_rsp && (hit_cnt_o != 16'hFFFF)) begin
                hit_cnt_o <= hit_cnt_o + 16'd1;
            end
            if (w_fill_done && (miss_cnt_o != 16'hFFFF)) begin
                miss_cnt_o <= miss_cnt_o + 16'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire
